// File: rtl/sysu_parity_serial_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB-first, parity, stop(1).
// Samples the synchronized line at mid-bit, checks parity and flags framing errors.
module sysu_parity_serial_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter bit ODD          = 1'b0,
    parameter int Delay        = 0
) (
    input  logic              CLK,
    input  logic              CLR_n,
    input  logic              RXD,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              VALID,
    output logic              PERR,
    output logic              FERR,
    output logic              BUSY
);

    // state       | meaning
    // S_IDLE      | line idle, waiting for rs = 0
    // S_START     | timing to middle of start bit, glitch rejection
    // S_DATA      | sampling data bits LSB first
    // S_PARITY    | sampling parity bit
    // S_STOP      | sampling stop bit, publishing the frame
    // S_WAIT_IDLE | stop bit was 0, waiting for the line to return high
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    // Delay only exists for library compatibility; outputs here are zero-delay.
    if (DATA_W < 1 || DATA_W > 16 || CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || Delay < 0) begin : g_param_check
        $error("sysu_parity_serial_rx: illegal parameter combination");
    end

    state_t            r_state;
    logic              r_sync1;
    logic              r_rs;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_word;
    logic              r_acc;
    logic              r_perr_next;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid;
    logic              r_perr;
    logic              r_ferr;
    logic              r_busy;

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            r_sync1 <= 1'b1;
            r_rs    <= 1'b1;
        end else begin
            r_sync1 <= RXD;
            r_rs    <= r_sync1;
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_acc       <= 1'b0;
            r_perr_next <= 1'b0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rs) begin
                        // The counter tracks cycles since the detect cycle, which itself is count 0.
                        r_state <= S_START;
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (r_rs) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                            r_acc   <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == BIT_M1) begin
                        r_cnt         <= '0;
                        r_word[r_idx] <= r_rs;
                        r_acc         <= r_acc ^ r_rs;
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_cnt == BIT_M1) begin
                        r_cnt       <= '0;
                        r_perr_next <= r_acc ^ r_rs ^ ODD;
                        r_state     <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == BIT_M1) begin
                        r_cnt      <= '0;
                        r_data_out <= r_word;
                        r_perr     <= r_perr_next;
                        r_ferr     <= ~r_rs;
                        r_valid    <= 1'b1;
                        if (r_rs) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    r_cnt <= '0;
                    if (r_rs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign DATA_OUT = r_data_out;
    assign VALID    = r_valid;
    assign PERR     = r_perr;
    assign FERR     = r_ferr;
    assign BUSY     = r_busy;

endmodule

// File: tb/tb_sysu_parity_serial_rx.sv
// Scoreboard bench for sysu_parity_serial_rx: even-parity instance plus an odd-parity instance.
module tb_sysu_parity_serial_rx;

    localparam int CPB = 16;
    localparam int LAT = 170;   // start edge to VALID: 8 + 10*16 + 2

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         start;
    } exp_t;

    logic       CLK = 1'b0;
    logic       clr_n0 = 1'b0;
    logic       clr_n1 = 1'b0;
    logic       rxd0 = 1'b1;
    logic       rxd1 = 1'b1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, perr0, perr1, ferr0, ferr1, busy0, busy1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    sysu_parity_serial_rx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .ODD(1'b0), .Delay(0)) dut0 (
        .CLK(CLK), .CLR_n(clr_n0), .RXD(rxd0), .DATA_OUT(data0), .VALID(valid0),
        .PERR(perr0), .FERR(ferr0), .BUSY(busy0)
    );

    sysu_parity_serial_rx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .ODD(1'b1), .Delay(0)) dut1 (
        .CLK(CLK), .CLR_n(clr_n1), .RXD(rxd1), .DATA_OUT(data1), .VALID(valid1),
        .PERR(perr1), .FERR(ferr1), .BUSY(busy1)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive_bit(input int which, input logic b);
        if (which == 0) rxd0 = b;
        else rxd1 = b;
        idle(CPB);
    endtask

    // Caller is always 1 ns after a rising edge, so frames can be chained with no gap.
    task automatic send_frame(input int which, input logic [7:0] d, input logic par, input logic stp,
                              input logic exp_perr, input logic exp_ferr);
        exp_t e;
        e.data  = d;
        e.perr  = exp_perr;
        e.ferr  = exp_ferr;
        e.start = cyc;
        if (which == 0) q0.push_back(e);
        else q1.push_back(e);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        drive_bit(which, par);
        drive_bit(which, stp);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (valid0) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("dut0_data", {24'd0, data0}, {24'd0, e.data});
                chk("dut0_perr", {31'd0, perr0}, {31'd0, e.perr});
                chk("dut0_ferr", {31'd0, ferr0}, {31'd0, e.ferr});
                chk("dut0_latency", cyc - e.start, LAT);
            end
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (valid1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("dut1_data", {24'd0, data1}, {24'd0, e.data});
                chk("dut1_perr", {31'd0, perr1}, {31'd0, e.perr});
                chk("dut1_ferr", {31'd0, ferr1}, {31'd0, e.ferr});
                chk("dut1_latency", cyc - e.start, LAT);
            end
        end
    end

    initial begin
        idle(3);
        chk("reset_outputs0", {20'd0, data0, valid0, perr0, ferr0, busy0}, 32'd0);
        chk("reset_outputs1", {20'd0, data1, valid1, perr1, ferr1, busy1}, 32'd0);
        clr_n0 = 1'b1;
        clr_n1 = 1'b1;
        idle(5);

        // Clean frame, then busy must have dropped
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("busy_after_frame", {31'd0, busy0}, 32'd0);

        // Wrong parity, then a good frame clears PERR
        send_frame(0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("perr_held", {31'd0, perr0}, 32'd1);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Stop bit 0 with line held low
        send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(100);
        chk("busy_line_low", {31'd0, busy0}, 32'd1);
        chk("data_held", {24'd0, data0}, 32'h0F);
        chk("ferr_held", {31'd0, ferr0}, 32'd1);
        rxd0 = 1'b1;
        idle(6);
        chk("busy_line_released", {31'd0, busy0}, 32'd0);
        idle(10);

        // 4-cycle glitch is rejected
        rxd0 = 1'b0;
        idle(4);
        rxd0 = 1'b1;
        chk("busy_glitch", {31'd0, busy0}, 32'd1);
        idle(8);
        chk("busy_after_glitch", {31'd0, busy0}, 32'd0);
        idle(10);
        send_frame(0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);

        // Back-to-back frames with no idle gap
        send_frame(0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);

        // Reset during data bit 4 of a 0x81 frame
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        rxd0 = 1'b0;
        idle(8);
        chk("busy_mid_frame", {31'd0, busy0}, 32'd1);
        clr_n0 = 1'b0;
        #1;
        chk("reset_mid_frame", {20'd0, data0, valid0, perr0, ferr0, busy0}, 32'd0);
        rxd0 = 1'b1;
        idle(4);
        clr_n0 = 1'b1;
        idle(40);
        chk("busy_after_abort", {31'd0, busy0}, 32'd0);
        send_frame(0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);

        // Odd-parity instance
        send_frame(1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(5);
        send_frame(1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(5);

        chk("dut0_frames_outstanding", q0.size(), 32'd0);
        chk("dut1_frames_outstanding", q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
